// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control: Moore FSM with memory ready/timeout, retire counter and sticky trap.
// Optional macro MULTICYCLE_JUMP_EN adds the j (000010) instruction through the JUMP state.
module multicycle_control #(
  parameter int OPCODE_W = 6,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic [3:0]          state,
  output logic [CNT_W-1:0]    instr_count,
  output logic                trap,
  output logic [1:0]          trap_cause
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_WB_MEM   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_BRANCH   = 4'd8,
    S_EXEC_I   = 4'd9,
    S_WB_I     = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
`endif

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t             state_reg, state_next;
  logic [7:0]         wait_reg, wait_next;
  logic               is_sw_reg, is_sw_next;
  logic [CNT_W-1:0]   count_reg;
  logic               trap_reg;
  logic [1:0]         cause_reg, cause_next;
  logic               retire;
  logic               timed_out;
  logic               waiting;

  // wait_reg holds the number of ready-low cycles already spent in this state
  assign timed_out = (wait_reg == WAIT_LAST) && !mem_ready;

  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    is_sw_next = is_sw_reg;
    retire     = 1'b0;
    waiting    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        waiting = !mem_ready;
        if (mem_ready) begin
          state_next = S_DECODE;
        end else if (timed_out) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        is_sw_next = (opcode == OP_SW);
        if (opcode == OP_RTYPE) begin
          state_next = S_EXEC_R;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          state_next = S_MEM_ADDR;
        end else if (opcode == OP_BEQ) begin
          state_next = S_BRANCH;
        end else if (opcode == OP_ADDI) begin
          state_next = S_EXEC_I;
`ifdef MULTICYCLE_JUMP_EN
        end else if (opcode == OP_J) begin
          state_next = S_JUMP;
`endif
        end else begin
          state_next = S_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end
      end
      S_MEM_ADDR: state_next = is_sw_reg ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        waiting = !mem_ready;
        if (mem_ready) begin
          state_next = S_WB_MEM;
        end else if (timed_out) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_MEM_WR: begin
        waiting = !mem_ready;
        if (mem_ready) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end else if (timed_out) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_EXEC_R: state_next = S_WB_R;
      S_EXEC_I: state_next = S_WB_I;
      S_WB_MEM, S_WB_R, S_WB_I, S_BRANCH: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
`endif
      S_TRAP: state_next = S_TRAP;
      default: begin
        // unused encodings (and JUMP when j is not built in) are illegal
        state_next = S_TRAP;
        cause_next = CAUSE_ILLEGAL;
      end
    endcase
  end

  always_comb begin
    wait_next = wait_reg;
    if (state_next != state_reg) begin
      wait_next = 8'd0;
    end else if (waiting) begin
      wait_next = wait_reg + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
      wait_reg  <= 8'd0;
      is_sw_reg <= 1'b0;
      count_reg <= '0;
      trap_reg  <= 1'b0;
      cause_reg <= CAUSE_NONE;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      is_sw_reg <= is_sw_next;
      cause_reg <= cause_next;
      if (state_next == S_TRAP) begin
        trap_reg <= 1'b1;
      end
      if (retire) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  // Moore outputs; only FETCH looks at mem_ready, and reset masks everything
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 2'b00;
    pc_source     = 2'd0;
    if (!rst) begin
      case (state_reg)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'd1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = 2'd3;
        S_MEM_ADDR, S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'd1;
        end
        S_WB_I: reg_write = 1'b1;
`ifdef MULTICYCLE_JUMP_EN
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'd2;
        end
`endif
        default: ;
      endcase
    end
  end

  assign state       = state_reg;
  assign instr_count = count_reg;
  assign trap        = trap_reg;
  assign trap_cause  = cause_reg;

endmodule
